// File: rtl/embedded_system_dual_memory.sv
// Dual-port Avalon-MM word memory: byte lanes, fixed 1/2-cycle read latency, sticky out-of-range flags.
// Define EMBEDDED_SYSTEM_DUAL_MEMORY_BYPASS_EN for new-data read-during-write (default returns old data).
module embedded_system_dual_memory #(
  parameter string INIT_FILE    = "embedded_system_memory.hex",
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    DEPTH        = 49152,
  parameter int    READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_oor,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_oor
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  en;
  logic [1:0]            rd, wr_ok, acc, in_rng;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rword [2];

  logic [1:0]            p_v, q_v, oor_q;
  logic [DATA_WIDTH-1:0] p_d [2];
  logic [DATA_WIDTH-1:0] q_d [2];

  // s2 loses every lane s1 also writes when both target the same word
  always_comb begin
    en       = clken & ~reset_req;
    addr[0]  = s1_address;
    addr[1]  = s2_address;
    wdata[0] = s1_writedata;
    wdata[1] = s2_writedata;
    in_rng[0] = {1'b0, s1_address} < DEPTH_LIM;
    in_rng[1] = {1'b0, s2_address} < DEPTH_LIM;
    rd[0]  = s1_chipselect & s1_read & ~s1_write & en;
    rd[1]  = s2_chipselect & s2_read & ~s2_write & en;
    acc[0] = s1_chipselect & (s1_read | s1_write) & en;
    acc[1] = s2_chipselect & (s2_read | s2_write) & en;
    wr_ok[0] = s1_chipselect & s1_write & en & in_rng[0] & ~reset;
    wr_ok[1] = s2_chipselect & s2_write & en & in_rng[1] & ~reset;
    be[0] = s1_byteenable;
    be[1] = s2_byteenable;
    if (wr_ok[0] && (s1_address == s2_address))
      be[1] = s2_byteenable & ~s1_byteenable;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rword[p] = '0;
      if (in_rng[p]) begin
        rword[p] = mem[addr[p]];
`ifdef EMBEDDED_SYSTEM_DUAL_MEMORY_BYPASS_EN
        for (int w = 0; w < 2; w++)
          for (int b = 0; b < NB; b++)
            if (wr_ok[w] && be[w][b] && (addr[w] == addr[p]))
              rword[p][b*8 +: 8] = wdata[w][b*8 +: 8];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < NB; b++)
        if (wr_ok[p] && be[p][b])
          mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
  end

  // Read pipeline and sticky flags; readdata only moves when a valid word arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      p_v   <= '0;
      q_v   <= '0;
      oor_q <= '0;
      for (int p = 0; p < 2; p++) begin
        p_d[p] <= '0;
        q_d[p] <= '0;
      end
    end else if (en) begin
      for (int p = 0; p < 2; p++) begin
        oor_q[p] <= oor_q[p] | (acc[p] & ~in_rng[p]);
        if (READ_LATENCY == 2) begin
          p_v[p] <= rd[p];
          if (rd[p]) p_d[p] <= rword[p];
          q_v[p] <= p_v[p];
          if (p_v[p]) q_d[p] <= p_d[p];
        end else begin
          q_v[p] <= rd[p];
          if (rd[p]) q_d[p] <= rword[p];
        end
      end
    end
  end

  assign s1_readdata      = q_d[0];
  assign s2_readdata      = q_d[1];
  assign s1_readdatavalid = q_v[0];
  assign s2_readdatavalid = q_v[1];
  assign s1_oor           = oor_q[0];
  assign s2_oor           = oor_q[1];

endmodule

// File: tb/tb_embedded_system_dual_memory.sv
// Scoreboard bench for embedded_system_dual_memory at READ_LATENCY=2; expectations are hand-computed.
module tb_embedded_system_dual_memory;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic [NB-1:0] s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_oor, s2_oor;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   ecyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  embedded_system_dual_memory #(
    .INIT_FILE(""), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(49152), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_oor(s1_oor),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_oor(s2_oor)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle();
    {s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write} = '0;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
  endtask

  task automatic applyStimulus(input int port, input bit rd, input bit wr, input logic [AW-1:0] a,
                               input logic [NB-1:0] be, input logic [DW-1:0] wd);
    if (port == 1) begin
      s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
      s1_address = a; s1_byteenable = be; s1_writedata = wd;
    end else begin
      s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
      s2_address = a; s2_byteenable = be; s2_writedata = wd;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Expected word arrives two enabled cycles after the cycle the read is presented
  task automatic pushExp(input int port, input logic [DW-1:0] data);
    exp_t e;
    e.data = data;
    e.due  = ecyc + 2;
    if (port == 1) q1.push_back(e);
    else           q2.push_back(e);
  endtask

  task automatic issueWrite(input int port, input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
    applyStimulus(port, 1'b0, 1'b1, a, be, wd);
    step();
  endtask

  task automatic issueRead(input int port, input logic [AW-1:0] a, input logic [DW-1:0] data);
    applyStimulus(port, 1'b1, 1'b0, a, '0, '0);
    pushExp(port, data);
    step();
  endtask

  task automatic monitorPort(input int port, input logic v, input logic [DW-1:0] d);
    exp_t e;
    bit   have;
    have = (port == 1) ? (q1.size() > 0) : (q2.size() > 0);
    if (have) e = (port == 1) ? q1[0] : q2[0];
    if (v) begin
      if (!have) begin
        checkOutput($sformatf("s%0d unexpected readdatavalid", port), {31'b0, v}, 32'd0);
      end else begin
        if (port == 1) void'(q1.pop_front());
        else           void'(q2.pop_front());
        checkOutput($sformatf("s%0d readdata", port), d, e.data);
        checkOutput($sformatf("s%0d read latency (enabled cycle)", port), ecyc, e.due);
      end
    end else if (have && (e.due <= ecyc)) begin
      if (port == 1) void'(q1.pop_front());
      else           void'(q2.pop_front());
      checkOutput($sformatf("s%0d missing readdatavalid", port), {31'b0, v}, 32'd1);
    end
  endtask

  // Only enabled, non-reset cycles consume an output pulse
  always @(negedge clk) begin
    if (!reset && clken && !reset_req) begin
      monitorPort(1, s1_readdatavalid, s1_readdata);
      monitorPort(2, s2_readdatavalid, s2_readdata);
      ecyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset s1_readdatavalid", s1_readdatavalid, 0);
    checkOutput("reset s1_readdata", s1_readdata, 0);
    checkOutput("reset s1_oor", s1_oor, 0);
    checkOutput("reset s2_readdatavalid", s2_readdatavalid, 0);
    checkOutput("reset s2_oor", s2_oor, 0);

    $display("[TB] basic write/read and first cycle after reset");
    issueWrite(1, 16'd5, 4'hF, 32'h11223344);
    issueRead(1, 16'd5, 32'h11223344);
    issueWrite(2, 16'd1, 4'hF, 32'hA5A5A5A5);
    issueWrite(2, 16'd2, 4'hF, 32'h5A5A5A5A);
    issueWrite(1, 16'h10, 4'hF, 32'h0);
    issueWrite(1, 16'd0, 4'hF, 32'h0);
    issueWrite(1, 16'd3, 4'hF, 32'h0);
    issueWrite(2, 16'd4, 4'hF, 32'h01020304);

    $display("[TB] back-to-back dual-port reads");
    applyStimulus(1, 1'b1, 1'b0, 16'd1, '0, '0); pushExp(1, 32'hA5A5A5A5);
    applyStimulus(2, 1'b1, 1'b0, 16'd5, '0, '0); pushExp(2, 32'h11223344);
    step();
    applyStimulus(1, 1'b1, 1'b0, 16'd2, '0, '0); pushExp(1, 32'h5A5A5A5A);
    applyStimulus(2, 1'b1, 1'b0, 16'd1, '0, '0); pushExp(2, 32'hA5A5A5A5);
    step();
    issueRead(1, 16'd5, 32'h11223344);

    $display("[TB] byte enables and same-address dual write");
    issueWrite(2, 16'h10, 4'b0101, 32'hAABBCCDD);
    issueRead(1, 16'h10, 32'h00BB00DD);
    applyStimulus(1, 1'b0, 1'b1, 16'd7, 4'b0011, 32'h11111111);
    applyStimulus(2, 1'b0, 1'b1, 16'd7, 4'b1111, 32'h22222222);
    step();
    issueRead(2, 16'd7, 32'h22221111);
    applyStimulus(1, 1'b1, 1'b1, 16'd9, 4'hF, 32'hCAFEF00D);
    step();
    issueRead(1, 16'd9, 32'hCAFEF00D);

    $display("[TB] read during cross-port write");
    applyStimulus(1, 1'b0, 1'b1, 16'd3, 4'hF, 32'hDEADBEEF);
    applyStimulus(2, 1'b1, 1'b0, 16'd3, '0, '0);
`ifdef EMBEDDED_SYSTEM_DUAL_MEMORY_BYPASS_EN
    pushExp(2, 32'hDEADBEEF);
`else
    pushExp(2, 32'h00000000);
`endif
    step();
    issueRead(2, 16'd3, 32'hDEADBEEF);
    applyStimulus(2, 1'b0, 1'b1, 16'd4, 4'b0011, 32'hFFFFFFFF);
    applyStimulus(1, 1'b1, 1'b0, 16'd4, '0, '0);
`ifdef EMBEDDED_SYSTEM_DUAL_MEMORY_BYPASS_EN
    pushExp(1, 32'h0102FFFF);
`else
    pushExp(1, 32'h01020304);
`endif
    step();
    issueRead(1, 16'd4, 32'h0102FFFF);

    $display("[TB] out-of-range accesses");
    issueWrite(1, 16'hC000, 4'hF, 32'h12345678);
    checkOutput("s1_oor after oor write", s1_oor, 1);
    checkOutput("s2_oor untouched", s2_oor, 0);
    issueRead(1, 16'hC000, 32'h0);
    issueRead(1, 16'd0, 32'h0);
    issueRead(2, 16'hFFFF, 32'h0);
    checkOutput("s2_oor after oor read", s2_oor, 1);
    repeat (4) step();
    checkOutput("s1_oor sticky", s1_oor, 1);

    $display("[TB] clock-enable stalls");
    issueRead(1, 16'd5, 32'h11223344);
    clken = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 16'd2, '0, '0);
    applyStimulus(2, 1'b0, 1'b1, 16'd5, 4'hF, 32'hFFFFFFFF);
    step();
    step();
    step();
    clken = 1'b1;
    issueRead(2, 16'd1, 32'hA5A5A5A5);
    reset_req = 1'b1;
    step();
    step();
    reset_req = 1'b0;
    issueRead(1, 16'd5, 32'h11223344);
    repeat (4) step();

    $display("[TB] reset with read in flight");
    applyStimulus(1, 1'b1, 1'b0, 16'd2, '0, '0);
    step();
    reset = 1'b1;
    clken = 1'b0;
    applyStimulus(2, 1'b0, 1'b1, 16'd1, 4'hF, 32'hFFFFFFFF);
    step();
    reset = 1'b0;
    clken = 1'b1;
    checkOutput("post-reset s1_readdatavalid", s1_readdatavalid, 0);
    checkOutput("post-reset s1_readdata", s1_readdata, 0);
    checkOutput("post-reset s2_readdata", s2_readdata, 0);
    checkOutput("post-reset s1_oor", s1_oor, 0);
    checkOutput("post-reset s2_oor", s2_oor, 0);
    repeat (3) step();
    issueRead(1, 16'd1, 32'hA5A5A5A5);
    issueRead(2, 16'd2, 32'h5A5A5A5A);
    repeat (5) step();

    checkOutput("s1 scoreboard drained", q1.size(), 0);
    checkOutput("s2 scoreboard drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/embedded_system_dual_memory.md
EMBEDDED_SYSTEM_DUAL_MEMORY -- requirements
Module: embedded_system_dual_memory

Interface
REQ-001 SHALL have parameter INIT_FILE, default "embedded_system_memory.hex": contents loaded at configuration.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width, multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: word address width.
REQ-004 SHALL have parameter DEPTH, default 49152: words implemented, at most 2**ADDR_WIDTH.
REQ-005 SHALL have parameter READ_LATENCY, default 1: read latency in enabled cycles, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port clken, input, 1 bit: global clock enable.
REQ-009 SHALL have port reset_req, input, 1 bit: when high, gates the clock enable exactly as clken low does.
REQ-010 SHALL have ports s1_address and s2_address, input, ADDR_WIDTH bits: word address per port.
REQ-011 SHALL have ports s1_byteenable and s2_byteenable, input, DATA_WIDTH/8 bits: write byte lanes.
REQ-012 SHALL have ports s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read and s2_write, input, 1 bit each: Avalon-MM slave controls.
REQ-013 SHALL have ports s1_writedata and s2_writedata, input, DATA_WIDTH bits.
REQ-014 SHALL have ports s1_readdata and s2_readdata, output, DATA_WIDTH bits.
REQ-015 SHALL have ports s1_readdatavalid and s2_readdatavalid, output, 1 bit.
REQ-016 SHALL have ports s1_oor and s2_oor, output, 1 bit: sticky flag, set by any out-of-range access.

Function
REQ-017 SHALL define en = clken & ~reset_req; when en is low, memory, pipelines, outputs and flags SHALL hold.
REQ-018 SHALL define a port write as chipselect & write & en, and SHALL update only the lanes whose byteenable bit is 1 at the next edge.
REQ-019 SHALL define a port read as chipselect & read & ~write & en; when chipselect, read and write are all high, the access SHALL be treated as a write only.
REQ-020 SHALL, for a read, assert readdatavalid for one enabled cycle with readdata exactly READ_LATENCY enabled cycles after the request; back-to-back reads SHALL pipeline at one per cycle.
REQ-021 SHALL hold readdata at its last value while readdatavalid is low.
REQ-022 SHALL, when both ports write the same address in one cycle, give s1 every lane it enables; s2 SHALL write only the lanes s1 does not enable.
REQ-023 SHALL return, for a read on one port while the other port writes the same address, data per REQ-034/REQ-035.
REQ-024 SHALL treat address >= DEPTH as out of range: a write is discarded; a read still returns readdatavalid with readdata = 0; the port's oor flag sets.
REQ-025 SHALL hold oor high until reset.
REQ-026 SHALL never stall a request: no waitrequest, fixed latency.

Reset
REQ-027 SHALL, when reset is sampled high, clear readdatavalid, readdata, oor and all pipeline stages to 0 on that edge, regardless of en.
REQ-028 SHALL NOT alter memory contents on reset.
REQ-029 SHALL discard any read in flight at reset, producing no readdatavalid afterwards.
REQ-030 SHALL give reset priority over simultaneous requests; accesses in the reset cycle have no effect.
REQ-031 SHALL accept requests in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL provide macro EMBEDDED_SYSTEM_DUAL_MEMORY_BYPASS_EN to select read-during-write behaviour.
REQ-033 SHALL keep the REQ-023 cross-port case covered by REQ-034/REQ-035.
REQ-034 SHALL, with the macro defined, return new data when a read coincides with a same- or cross-port write to the same address; enabled lanes come from the merged REQ-022 write data and other lanes from stored data.
REQ-035 SHALL, with the macro undefined, return old (pre-write) data for all lanes in that case.

Verification
REQ-036 SHALL cover basic read: mem[5] = 0x11223344; s1 read of 5 with READ_LATENCY=2 -> s1_readdatavalid high exactly 2 cycles later, s1_readdata = 0x11223344.
REQ-037 SHALL cover byte-enable write: s2 write 0xAABBCCDD with byteenable 0101 to 0x10 holding 0 -> later read = 0x00BB00DD.
REQ-038 SHALL cover same-address dual write: s1 0x11111111 with be 0011 and s2 0x22222222 with be 1111, both to 7 -> mem[7] = 0x22221111.
REQ-039 SHALL cover read-during-write: mem[3] = 0; s2 reads 3 while s1 writes 0xDEADBEEF with be 1111 -> 0xDEADBEEF with the macro defined, 0x00000000 without.
REQ-040 SHALL cover out of range: DEPTH=49152; s1 write and read at 0xC000 -> no memory change, readdata = 0, s1_oor = 1 until reset.
REQ-041 SHALL cover stall and reset: clken low for 3 cycles mid-read -> readdatavalid delayed 3 cycles with data intact; reset asserted while a read is in flight -> no readdatavalid, outputs 0.
